// File: rtl/integral_img_stream.sv
// integral_img_stream: raster-order streaming integral image (and optional squared integral) generator
module integral_img_stream #(
  parameter int PIX_W = 8,
  parameter int MAX_W = 256,
  parameter int MAX_H = 256,
  parameter int SUM_W = 32,
  parameter int SQ_EN = 1,
  parameter int SQ_W  = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      width,
  input  logic [15:0]      height,
  input  logic             start,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_pix,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [SQ_W-1:0]  out_sqsum,
  output logic [15:0]      out_x,
  output logic [15:0]      out_y,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             err_cfg
);
  localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  state_e state_q, state_d;
  logic [15:0] w_q, h_q, x_q, y_q;
  logic [SUM_W-1:0] row_q, row_d, ii_d, sum_q;
  logic [SUM_W-1:0] lb [MAX_W];
  logic ov_q, last_q, done_q, err_q, acc, bad_cfg, x_end, y_end, take_last;
  logic [AW-1:0] xi;
  logic [15:0] ox_q, oy_q;
  assign in_ready  = (state_q == RUN) && (!ov_q || out_ready);
  assign acc       = in_valid && in_ready;
  assign bad_cfg   = width == '0 || height == '0 || 32'(width) > 32'(MAX_W) || 32'(height) > 32'(MAX_H);
  assign x_end     = x_q == w_q - 16'd1;
  assign y_end     = y_q == h_q - 16'd1;
  assign take_last = ov_q && out_ready && last_q;
  assign xi        = x_q[AW-1:0];
  assign row_d     = (x_q == '0 ? '0 : row_q) + SUM_W'(in_pix);
  assign ii_d      = row_d + (y_q == '0 ? '0 : lb[xi]);
  assign out_valid = ov_q;
  assign out_sum   = sum_q;
  assign out_x     = ox_q;
  assign out_y     = oy_q;
  assign out_last  = last_q;
  assign busy      = state_q != IDLE;
  assign done      = done_q;
  assign err_cfg   = err_q;
  // next-state logic for the frame sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (start && !bad_cfg) ? RUN : IDLE;
      RUN:     state_d = (acc && x_end && y_end) ? DRAIN : RUN;
      DRAIN:   state_d = take_last ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  // control, counters, row accumulator and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w_q     <= '0;
      h_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      row_q   <= '0;
      sum_q   <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      last_q  <= 1'b0;
      ov_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= state_q == DRAIN && take_last;
      err_q   <= state_q == IDLE && start && bad_cfg;
      ov_q    <= acc || (ov_q && !out_ready);
      if (state_q == IDLE && start) begin
        w_q <= width;
        h_q <= height;
        x_q <= '0;
        y_q <= '0;
      end
      if (acc) begin
        row_q  <= row_d;
        x_q    <= x_end ? '0 : x_q + 16'd1;
        y_q    <= x_end ? y_q + 16'd1 : y_q;
        sum_q  <= ii_d;
        ox_q   <= x_q;
        oy_q   <= y_q;
        last_q <= x_end && y_end;
      end
    end
  end
  // line buffer holds the previous row's integral; row 0 masks stale contents so no clear is needed
  always_ff @(posedge clk) begin
    if (acc) lb[xi] <= ii_d;
  end
  generate
    if (SQ_EN != 0) begin : g_sq
      logic [SQ_W-1:0] rsq_q, rsq_d, iisq_d, sq_q;
      logic [SQ_W-1:0] lbs [MAX_W];
      logic [2*PIX_W-1:0] p2;
      assign p2        = in_pix * in_pix;
      assign rsq_d     = (x_q == '0 ? '0 : rsq_q) + SQ_W'(p2);
      assign iisq_d    = rsq_d + (y_q == '0 ? '0 : lbs[xi]);
      assign out_sqsum = sq_q;
      // squared row accumulator and output register
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rsq_q <= '0;
          sq_q  <= '0;
        end else if (acc) begin
          rsq_q <= rsq_d;
          sq_q  <= iisq_d;
        end
      end
      // squared-integral line buffer
      always_ff @(posedge clk) begin
        if (acc) lbs[xi] <= iisq_d;
      end
    end else begin : g_nosq
      assign out_sqsum = '0;
    end
  endgenerate
endmodule

// File: tb/tb_integral_img_stream.sv
// tb_integral_img_stream: randomized scoreboard bench for integral_img_stream against a direct-summation model
module tb_integral_img_stream;
  localparam int MW = 32, MH = 32;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0, out_ready = 1;
  logic [15:0] width = 0, height = 0;
  logic [7:0] in_pix = 0;
  logic in_ready, out_valid, out_last, busy, done, err_cfg;
  logic [15:0] out_sum, out_x, out_y;
  logic [47:0] out_sqsum;
  typedef struct packed {logic [15:0] s; logic [47:0] q; logic [15:0] x; logic [15:0] y; logic l;} exp_t;
  exp_t sb[$];
  exp_t held;
  logic hold_v = 0;
  int n_cmp = 0, n_bad = 0, busy_tot = 0;
  logic chk_en = 1, rnd_rdy = 0;

  integral_img_stream #(.PIX_W(8), .MAX_W(MW), .MAX_H(MH), .SUM_W(16), .SQ_EN(1), .SQ_W(48)) dut (
    .clk(clk), .rst_n(rst_n), .width(width), .height(height), .start(start),
    .in_valid(in_valid), .in_pix(in_pix), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_sqsum(out_sqsum), .out_x(out_x),
    .out_y(out_y), .out_last(out_last), .busy(busy), .done(done), .err_cfg(err_cfg));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial forever begin
    @(posedge clk);
    #1 out_ready = rnd_rdy ? 1'($urandom % 2) : 1'b1;
  end

  // monitor: scoreboard pops on every handshake, plus stall stability tracking
  always @(negedge clk) begin
    exp_t got, e;
    got = '{out_sum, out_sqsum, out_x, out_y, out_last};
    if (busy) busy_tot++;
    if (rst_n && hold_v) begin
      n_cmp++;
      if (!out_valid || got != held) begin
        n_bad++;
        $display("FAIL stall_stable: got v=%0b %h required v=1 %h", out_valid, got, held);
      end
    end
    if (rst_n && out_valid && out_ready && chk_en) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL out_word: got %h, required none (scoreboard empty)", got);
      end else begin
        e = sb.pop_front();
        if (got != e) begin
          n_bad++;
          $display("FAIL out_word: got sum=%0d sq=%0d x=%0d y=%0d last=%0b required sum=%0d sq=%0d x=%0d y=%0d last=%0b",
                   got.s, got.q, got.x, got.y, got.l, e.s, e.q, e.x, e.y, e.l);
        end
      end
    end
    hold_v = rst_n && out_valid && !out_ready;
    held = got;
  end

  task automatic check(input string nm, input longint got, input longint req);
    n_cmp++;
    if (got != req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", nm, got, req);
    end
  endtask

  task automatic do_start(input int w, input int h);
    @(posedge clk);
    #1 start = 1; width = 16'(w); height = 16'(h);
    @(posedge clk);
    #1 start = 0; width = 16'($urandom); height = 16'($urandom);
  endtask

  task automatic drive_pix(input int v, input bit gaps);
    bit a;
    if (gaps && $urandom % 3 == 0) begin
      in_valid = 0;
      repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
    in_valid = 1;
    in_pix = 8'(v);
    a = 0;
    for (int t = 0; t < 1000 && !a; t++) begin
      @(negedge clk);
      a = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    if (!a) check("accept_timeout", 0, 1);
  endtask

  // mode 0 constant, 1 ramp, 2 random pixels; model sums each rectangle directly
  task automatic run_frame(input int w, input int h, input int mode, input int val, input bit rr, input bit gaps);
    int p[];
    int b0, k;
    exp_t e;
    p = new[w * h];
    foreach (p[i]) p[i] = mode == 0 ? val : mode == 1 ? i % 256 : int'($urandom_range(0, 255));
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx++) begin
        longint s = 0, q = 0;
        for (int j = 0; j <= yy; j++)
          for (int i = 0; i <= xx; i++) begin
            s += p[j * w + i];
            q += p[j * w + i] * p[j * w + i];
          end
        e.s = s[15:0]; e.q = q[47:0]; e.x = 16'(xx); e.y = 16'(yy); e.l = xx == w - 1 && yy == h - 1;
        sb.push_back(e);
      end
    rnd_rdy = rr;
    b0 = busy_tot;
    do_start(w, h);
    foreach (p[i]) drive_pix(p[i], gaps);
    k = 0;
    while (k < 2000 && !done) begin @(negedge clk); k++; end
    check("done_seen", done, 1);
    @(posedge clk);
    #1;
    check("done_one_cycle", done, 0);
    check("busy_after", busy, 0);
    check("words_left", sb.size(), 0);
    if (!rr && !gaps) check("busy_cycles", busy_tot - b0, w * h + 1);
    rnd_rdy = 0;
    sb.delete();
  endtask

  task automatic bad_start(input int w, input int h);
    @(posedge clk);
    #1 start = 1; width = 16'(w); height = 16'(h); in_valid = 1;
    @(posedge clk);
    #1 start = 0;
    @(negedge clk);
    check("err_pulse", err_cfg, 1);
    check("err_busy", busy, 0);
    check("err_in_ready", in_ready, 0);
    @(negedge clk);
    check("err_one_cycle", err_cfg, 0);
    check("err_busy2", busy, 0);
    check("err_in_ready2", in_ready, 0);
    in_valid = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {out_valid, in_ready, out_sum, out_sqsum, out_x, out_y, out_last, busy, done, err_cfg}, 0);
    rst_n = 1;
    run_frame(4, 3, 0, 1, 0, 0);
    run_frame(MW, 2, 0, 255, 0, 0);
    run_frame(4, 3, 1, 0, 1, 0);
    run_frame(4, 3, 1, 0, 1, 1);
    bad_start(0, 4);
    bad_start(4, MH + 1);
    bad_start(MW + 1, 4);
    chk_en = 0;
    do_start(4, 3);
    for (int i = 0; i < 5; i++) drive_pix(7, 0);
    rst_n = 0;
    #1;
    check("midrst_outputs", {out_valid, in_ready, out_sum, out_sqsum, out_x, out_y, out_last, busy, done, err_cfg}, 0);
    @(posedge clk);
    #1 rst_n = 1; chk_en = 1;
    run_frame(4, 3, 0, 1, 0, 0);
    run_frame(MW, MH, 0, 255, 0, 0);
    run_frame(1, 1, 2, 0, 1, 0);
    for (int f = 0; f < 6; f++) run_frame($urandom_range(1, 8), $urandom_range(1, 8), 2, 0, 1, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
